ahb_apb_bridge: RTL and testbench

- AHB-Lite slave to APB master bridge (the bridge_top block), placed between the AHB master model and the APB peripheral model.
- Converts single and burst AHB read/write transfers into APB SETUP/ACCESS cycles.
- Stalls the AHB side through hreadyout while APB cycles complete.
- Single clock domain (hclk); the APB side is clocked by the same edge.

---
 rtl/ahb_apb_bridge_pkg.sv | 11 +
 rtl/ahb_apb_bridge_if.sv | 14 +
 rtl/ahb_apb_bridge_ahb_slave_if.sv | 41 ++++
 rtl/ahb_apb_bridge.sv | 63 ++++++
 tb/tb_ahb_apb_bridge.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ahb_apb_bridge_pkg.sv
// ahb_apb_pkg: shared AHB transfer encodings, response code and bridge FSM states.
package ahb_apb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   typedef enum logic [2:0] {
      IDLE, READ, RENABLE, WWAIT, WRITE, WRITEP, WENABLE, WENABLEP
   } state_e;
endpackage

// File: rtl/ahb_apb_bridge_if.sv
// ahb_apb_bridge_if: AHB-Lite slave side and APB master side signals of the bridge.
interface ahb_apb_bridge_if;
   logic [31:0] haddr, hwdata, hrdata, prdata, paddr, pwdata;
   logic [1:0]  htrans, hresp;
   logic        hwrite, hreadyin, hreadyout, pready, pwrite, penable, pselx;
   modport slave (
      input  haddr, hwdata, hwrite, htrans, hreadyin, prdata, pready,
      output paddr, pwrite, pwdata, penable, pselx, hreadyout, hresp, hrdata
   );
   modport master (
      output haddr, hwdata, hwrite, htrans, hreadyin, prdata, pready,
      input  paddr, pwrite, pwdata, penable, pselx, hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_apb_bridge_ahb_slave_if.sv
// ahb_slave_if: valid decode, AHB address/direction pipeline and write-data capture.
module ahb_slave_if
   import ahb_apb_pkg::*;
#(
   parameter logic [31:0] ADDR_LO = 32'h8000_0000,
   parameter logic [31:0] ADDR_HI = 32'h8C00_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] haddr_i,
   input  logic [31:0] hwdata_i,
   input  logic        hwrite_i,
   input  logic [1:0]  htrans_i,
   input  logic        hreadyin_i,
   input  logic        cap_i,
   output logic        valid_o,
   output logic [31:0] haddr_r_o,
   output logic        hwrite_r_o,
   output logic [31:0] hwdata_r_o
);
   logic [31:0] haddr_q, hwdata_q;
   logic        hwrite_q;
   assign valid_o = hreadyin_i && (htrans_i == HTRANS_NONSEQ || htrans_i == HTRANS_SEQ)
                    && haddr_i >= ADDR_LO && haddr_i < ADDR_HI;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         hwdata_q <= '0;
      end else begin
         if (valid_o) begin
            haddr_q  <= haddr_i;
            hwrite_q <= hwrite_i;
         end
         if (cap_i) hwdata_q <= hwdata_i;
      end
   end
   assign haddr_r_o  = haddr_q;
   assign hwrite_r_o = hwrite_q;
   assign hwdata_r_o = hwdata_q;
endmodule

// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB-Lite slave to APB master bridge; FSM plus registered APB outputs.
module ahb_apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter logic [31:0] ADDR_LO = 32'h8000_0000,
   parameter logic [31:0] ADDR_HI = 32'h8C00_0000
) (
   input logic             hclk,
   input logic             hreset,
   ahb_apb_bridge_if.slave bus
);
   state_e      state_q, state_d;
   logic [31:0] paddr_q, paddr_d, haddr_r, hwdata_r;
   logic        pselx_q, penable_q, pwrite_q, valid, hwrite_r, setup, access, cap;
   ahb_slave_if #(.ADDR_LO(ADDR_LO), .ADDR_HI(ADDR_HI)) u_slv (
      .clk_i(hclk), .rst_ni(hreset), .haddr_i(bus.haddr), .hwdata_i(bus.hwdata),
      .hwrite_i(bus.hwrite), .htrans_i(bus.htrans), .hreadyin_i(bus.hreadyin), .cap_i(cap),
      .valid_o(valid), .haddr_r_o(haddr_r), .hwrite_r_o(hwrite_r), .hwdata_r_o(hwdata_r)
   );
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:             state_d = valid ? (bus.hwrite ? WWAIT : READ) : IDLE;
         READ:             state_d = RENABLE;
         RENABLE, WENABLE: if (bus.pready) state_d = valid ? (bus.hwrite ? WWAIT : READ) : IDLE;
         WWAIT:            state_d = valid ? WRITEP : WRITE;
         WRITE:            state_d = valid ? WENABLEP : WENABLE;
         WRITEP:           state_d = WENABLEP;
         WENABLEP:         if (bus.pready) state_d = !hwrite_r ? READ : (valid ? WRITEP : WRITE);
         default:          state_d = IDLE;
      endcase
   end
   assign setup  = state_d inside {READ, WRITE, WRITEP};
   assign access = state_d inside {RENABLE, WENABLE, WENABLEP};
   // write data is still on hwdata when a write SETUP is entered, so it is loaded straight into pwdata
   assign cap    = state_d inside {WRITE, WRITEP};
   // a new transfer's address is only on the bus when SETUP follows IDLE or a plain ACCESS
   assign paddr_d = setup ? (state_q inside {IDLE, RENABLE, WENABLE} ? bus.haddr : haddr_r) : paddr_q;
   always_ff @(posedge hclk) begin
      if (!hreset) begin
         state_q   <= IDLE;
         paddr_q   <= '0;
         pselx_q   <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pselx_q   <= setup || access;
         penable_q <= access;
         pwrite_q  <= state_d inside {WRITE, WRITEP, WENABLE, WENABLEP};
      end
   end
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = hwdata_r;
   assign bus.pselx     = pselx_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.hreadyout = !(state_q inside {READ, WRITEP, WENABLEP})
                          && !(state_q inside {RENABLE, WENABLE} && !bus.pready);
   assign bus.hresp     = HRESP_OKAY;
   assign bus.hrdata    = bus.prdata;
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: directed AHB transfers against an APB responder with hand-computed expectations.
module tb_ahb_apb_bridge;
   import ahb_apb_pkg::*;
   logic hclk = 1'b0;
   logic hreset;
   int   n_cmp = 0, n_bad = 0, acc_cnt = 0, lows;
   logic [64:0] setups[$];
   logic [31:0] rdata[$];
   logic [31:0] wdat[4];
   logic [31:0] last_addr, last_data;
   logic        last_wr;
   ahb_apb_bridge_if bus ();
   ahb_apb_bridge dut (.hclk(hclk), .hreset(hreset), .bus(bus));
   always #5 hclk = ~hclk;
   assign bus.hreadyin = bus.hreadyout;
   assign bus.prdata   = (bus.paddr == 32'h8000_0004) ? 32'hDEAD_BEEF : {16'hC0DE, bus.paddr[15:0]};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   always @(negedge hclk) begin
      if (hreset && bus.pselx && !bus.penable) begin
         setups.push_back({bus.pwrite, bus.paddr, bus.pwdata});
         last_addr = bus.paddr;
         last_data = bus.pwdata;
         last_wr   = bus.pwrite;
      end
      if (hreset && bus.pselx && bus.penable) begin
         chk("acc_paddr", bus.paddr, last_addr);
         chk("acc_pwdata", bus.pwdata, last_data);
         chk("acc_pwrite", 32'(bus.pwrite), 32'(last_wr));
         if (bus.pready) acc_cnt++;
      end
   end
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge hclk);
         #1;
      end
   endtask
   task automatic pop_setup(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d);
      logic [64:0] s;
      if (setups.size() == 0) begin
         chk(tag, 32'd0, 32'd1);
         return;
      end
      s = setups.pop_front();
      chk(tag, 32'(s[64]), 32'(wr));
      chk(tag, s[63:32], a);
      if (wr) chk(tag, s[31:0], d);
   endtask
   task automatic pop_rd(input string tag, input logic [31:0] exp);
      if (rdata.size() == 0) begin
         chk(tag, 32'd0, 32'd1);
         return;
      end
      chk(tag, rdata.pop_front(), exp);
   endtask
   // pipelined AHB master: address of beat i overlaps data phase of beat i-1, both held while stalled
   task automatic ahb_xfer(input logic wr, input logic [31:0] a0, input int n, output int nlow);
      int   i = 0, t = 0;
      logic rdy;
      nlow = 0;
      while (i <= n && t < 60) begin
         bus.haddr  = a0 + 32'(4 * i);
         bus.htrans = (i == n) ? HTRANS_IDLE : (i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ);
         bus.hwrite = wr;
         bus.hwdata = (i > 0) ? wdat[i-1] : 32'd0;
         @(negedge hclk);
         rdy = bus.hreadyout;
         if (!rdy) nlow++;
         if (rdy && i > 0 && !wr) rdata.push_back(bus.hrdata);
         @(posedge hclk);
         #1;
         if (rdy) i++;
         t++;
      end
      if (i <= n) chk("xfer_timeout", 32'(t), 32'd0);
      bus.htrans = HTRANS_IDLE;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      hreset     = 1'b0;
      bus.haddr  = '0;
      bus.hwdata = '0;
      bus.hwrite = 1'b0;
      bus.htrans = HTRANS_IDLE;
      bus.pready = 1'b1;
      @(posedge hclk);
      #1;
      @(negedge hclk);
      chk("rst_pselx", 32'(bus.pselx), 32'd0);
      chk("rst_penable", 32'(bus.penable), 32'd0);
      chk("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
      chk("rst_hresp", 32'(bus.hresp), 32'd0);
      chk("rst_paddr", bus.paddr, 32'd0);
      @(posedge hclk);
      #1;
      hreset = 1'b1;
      idle(2);
      wdat[0] = 32'hA5A5_0001;
      acc_cnt = 0;
      ahb_xfer(1'b1, 32'h8000_0000, 1, lows);
      idle(3);
      chk("sw_lows", 32'(lows), 32'd0);
      chk("sw_nsetup", 32'(setups.size()), 32'd1);
      pop_setup("sw_setup", 1'b1, 32'h8000_0000, 32'hA5A5_0001);
      chk("sw_nacc", 32'(acc_cnt), 32'd1);
      chk("sw_idle_pselx", 32'(bus.pselx), 32'd0);
      chk("sw_idle_penable", 32'(bus.penable), 32'd0);
      wdat = '{32'd1, 32'd2, 32'd3, 32'd4};
      acc_cnt = 0;
      ahb_xfer(1'b1, 32'h8000_0010, 4, lows);
      idle(3);
      chk("bw_lows", 32'(lows), 32'd4);
      chk("bw_nsetup", 32'(setups.size()), 32'd4);
      for (int k = 0; k < 4; k++) pop_setup("bw_setup", 1'b1, 32'h8000_0010 + 32'(4 * k), 32'(k + 1));
      chk("bw_nacc", 32'(acc_cnt), 32'd4);
      acc_cnt = 0;
      ahb_xfer(1'b0, 32'h8000_0004, 1, lows);
      idle(3);
      chk("sr_lows", 32'(lows), 32'd1);
      pop_setup("sr_setup", 1'b0, 32'h8000_0004, 32'd0);
      pop_rd("sr_hrdata", 32'hDEAD_BEEF);
      chk("sr_nacc", 32'(acc_cnt), 32'd1);
      acc_cnt = 0;
      ahb_xfer(1'b0, 32'h8000_0020, 4, lows);
      idle(3);
      chk("br_lows", 32'(lows), 32'd4);
      chk("br_nsetup", 32'(setups.size()), 32'd4);
      for (int k = 0; k < 4; k++) pop_setup("br_setup", 1'b0, 32'h8000_0020 + 32'(4 * k), 32'd0);
      for (int k = 0; k < 4; k++) pop_rd("br_hrdata", 32'hC0DE_0020 + 32'(4 * k));
      chk("br_nacc", 32'(acc_cnt), 32'd4);
      acc_cnt = 0;
      bus.pready = 1'b0;
      fork
         ahb_xfer(1'b0, 32'h8000_0008, 1, lows);
         begin
            int w = 0;
            do begin
               @(negedge hclk);
               w++;
            end while (!(bus.pselx && bus.penable) && w < 30);
            chk("st_found", 32'(bus.penable), 32'd1);
            chk("st_rdy_a", 32'(bus.hreadyout), 32'd0);
            @(posedge hclk);
            #1;
            @(negedge hclk);
            chk("st_hold_penable", 32'(bus.penable), 32'd1);
            chk("st_hold_paddr", bus.paddr, 32'h8000_0008);
            chk("st_rdy_b", 32'(bus.hreadyout), 32'd0);
            @(posedge hclk);
            #1;
            bus.pready = 1'b1;
            @(negedge hclk);
            chk("st_rdy_done", 32'(bus.hreadyout), 32'd1);
            chk("st_penable_done", 32'(bus.penable), 32'd1);
         end
      join
      idle(3);
      chk("st_lows", 32'(lows), 32'd3);
      pop_setup("st_setup", 1'b0, 32'h8000_0008, 32'd0);
      pop_rd("st_hrdata", 32'hC0DE_0008);
      chk("st_nacc", 32'(acc_cnt), 32'd1);
      acc_cnt = 0;
      wdat[0] = 32'hBAD0_0001;
      ahb_xfer(1'b1, 32'h0000_0100, 1, lows);
      idle(3);
      chk("oor_lows", 32'(lows), 32'd0);
      ahb_xfer(1'b1, 32'h8C00_0000, 1, lows);
      idle(3);
      chk("hi_lows", 32'(lows), 32'd0);
      chk("oor_nsetup", 32'(setups.size()), 32'd0);
      chk("oor_nacc", 32'(acc_cnt), 32'd0);
      wdat[0] = 32'h0BAD_F00D;
      ahb_xfer(1'b1, 32'h8BFF_FFFC, 1, lows);
      idle(3);
      pop_setup("top_setup", 1'b1, 32'h8BFF_FFFC, 32'h0BAD_F00D);
      chk("top_nacc", 32'(acc_cnt), 32'd1);
      acc_cnt = 0;
      bus.haddr  = 32'h8000_0040;
      bus.htrans = HTRANS_NONSEQ;
      bus.hwrite = 1'b1;
      idle(1);
      bus.htrans = HTRANS_IDLE;
      bus.hwdata = 32'hFFFF_FFFF;
      idle(1);
      chk("mr_pselx_pre", 32'(bus.pselx), 32'd1);
      hreset = 1'b0;
      @(posedge hclk);
      @(negedge hclk);
      chk("mr_pselx", 32'(bus.pselx), 32'd0);
      chk("mr_penable", 32'(bus.penable), 32'd0);
      chk("mr_pwrite", 32'(bus.pwrite), 32'd0);
      chk("mr_paddr", bus.paddr, 32'd0);
      chk("mr_pwdata", bus.pwdata, 32'd0);
      chk("mr_hreadyout", 32'(bus.hreadyout), 32'd1);
      @(posedge hclk);
      #1;
      hreset = 1'b1;
      idle(4);
      chk("mr_dropped", 32'(acc_cnt), 32'd0);
      setups.delete();
      ahb_xfer(1'b0, 32'h8000_0004, 1, lows);
      idle(3);
      pop_setup("rec_setup", 1'b0, 32'h8000_0004, 32'd0);
      pop_rd("rec_hrdata", 32'hDEAD_BEEF);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
